uart_transceiver: RTL and testbench
===================================

# uart_transceiver

Byte-wide asynchronous serial transceiver for the RS-422 link. It combines a transmit path (8N1 frame onto `txd`) and a receive path (8N1 frame from `rxd`) under one sample clock, with bit timing derived internally at 16× oversampling. Host logic writes bytes with an active-low strobe and reads received bytes with an active-low strobe and a ready flag. In board-level tests `txd` is wired straight to `rxd` as a loopback.

## Interface
- `OVERSAMPLE`, 16: `clk_sample` cycles per serial bit (≥4; even values only).
- `clk_sample`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `din`  in  8  byte to transmit; sampled on a write.
- `wrn`  in  1  active-low write strobe; a 1→0 transition requests a send.
- `txd`  out  1  serial output; idle high.
- `send_over`  out  1  high when the transmitter is idle; low while a frame is in flight.
- `rxd`  in  1  serial input; asynchronous to `clk_sample`.
- `dout`  out  8  last received byte.
- `rdn`  in  1  active-low read strobe; a 1→0 transition acknowledges `dout`.
- `data_ready`  out  1  high when an unread byte is in `dout`.

## Operation
- Frame: start bit (0), data bits 0..7 LSB first, stop bit (1). Each bit lasts `OVERSAMPLE` cycles.
- **Reset values:** `txd`=1, `send_over`=1, `dout`=0x00, `data_ready`=0. Both state machines return to IDLE. Edge-detect registers load 1. Reset in mid-frame aborts the frame immediately.
- **TX FSM:** IDLE → START → DATA(×8) → STOP → IDLE.
  - In IDLE, a `wrn` falling edge (registered previous value 1, current 0) latches `din` and enters START.
  - `wrn` edges outside IDLE are ignored. They are not queued.
- **RX path:**
  - `rxd` passes through a 2-FF synchronizer; a third register provides edge detection.
  - **RX FSM:** IDLE → START → DATA(×8) → STOP → IDLE.
  - In IDLE, a synchronized falling edge clears the bit counter and enters START.
  - At counter `OVERSAMPLE/2-1` the start bit is rechecked. If it reads 1 (glitch), the FSM returns to IDLE.
  - Each later bit is sampled every `OVERSAMPLE` cycles after the start-bit check, i.e. mid-bit.
  - Stop sample = 1: the shift register is copied to `dout` and `data_ready` is set.
  - Stop sample = 0 (framing error): the byte is discarded, and `dout` and `data_ready` are unchanged.
  - In both cases the FSM returns to IDLE on the stop sample and can accept a new start immediately.
- **Read handshake:** a `rdn` falling edge clears `data_ready`. Holding `rdn` low does not clear later bytes.
- **Overrun:** a new valid byte overwrites `dout` and `data_ready` stays 1.
- **Simultaneous set and clear:** if a byte completes in the same cycle as a `rdn` falling edge, set wins and `data_ready` stays 1.

## Timing
- **TX:** let T be the cycle in which `wrn`=0 is first sampled after 1.
  - `txd`=0 and `send_over`=0 from T+1 for 16 cycles.
  - Data bit i occupies cycles T+17+16i … T+32+16i.
  - Stop bit occupies T+145 … T+160.
  - `send_over`=1 at T+161.
- **RX:** let E be the edge at which `rxd` first reads 0.
  - The falling edge is detected at E+2.
  - The start-bit check occurs at E+9.
  - Bit i is sampled at E+25+16i.
  - The stop bit is sampled at E+153.
  - `dout` and `data_ready` update at E+154.
- **Loopback:** `data_ready` rises 154 cycles after `txd` falls.
- All outputs are registered.

## Configuration
- **`UART_PARITY_EN` defined:**
  - Both paths insert/expect an even-parity bit between bit 7 and stop, giving an 11-bit frame. The TX stop bit shifts to T+161…T+176.
  - RX discards a byte on parity mismatch, with the same handling as a framing error.
  - Adds output `parity_err` (1 bit, reset 0). It pulses high for one cycle on a mismatch.
- **Undefined:** 8N1 exactly as above; no `parity_err` port.

## Test plan
- **Reset:** hold `rst`=1 for 3 cycles mid-frame → `txd`=1, `send_over`=1, `data_ready`=0, `dout`=0x00 on the next cycle.
- **Transmit 0x4A:** `din`=0x4A, `wrn` 1→0 → `txd` sequence 0,0,1,0,1,0,0,1,0,1 (16 cycles each), then `send_over`=1 at T+161.
- **Loopback 0x4A then 0x73:** `txd`→`rxd` → `data_ready`=1 with `dout`=0x4A; after a `rdn` falling edge `data_ready`=0; second frame → `dout`=0x73, `data_ready`=1.
- **Framing error:** drive a frame of 0x55 with stop=0 → `dout` and `data_ready` unchanged; a following valid frame of 0xA5 is received correctly.
- **Glitch:** `rxd` low for 4 cycles → no reception, RX returns to IDLE.
- **Overrun and collision:** two frames without a read → `dout`=second byte, `data_ready`=1; a `rdn` edge on the completion cycle leaves `data_ready`=1.

Source files
------------

// File: rtl/uart_transceiver.sv
// rtl/uart_transceiver.sv - 8N1 UART transmit/receive pair at OVERSAMPLE clocks per bit
// Define UART_PARITY_EN for an even-parity bit before stop and a parity_err output.
module uart_transceiver #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk_sample,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       wrn,
    output logic       txd,
    output logic       send_over,
    input  logic       rxd,
    output logic [7:0] dout,
    input  logic       rdn,
    output logic       data_ready
`ifdef UART_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t          tx_state;
    logic [CW-1:0]   tx_cnt;
    logic [2:0]      tx_bit;
    logic [7:0]      tx_shift;
    logic            wrn_prev;
`ifdef UART_PARITY_EN
    logic            tx_par;
`endif

    always_ff @(posedge clk_sample) begin
        if (rst) begin
            tx_state  <= IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_shift  <= '0;
            txd       <= 1'b1;
            send_over <= 1'b1;
            wrn_prev  <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par    <= 1'b0;
`endif
        end else begin
            wrn_prev <= wrn;
            if (tx_state == IDLE) begin
                if (wrn_prev && !wrn) begin
                    tx_shift  <= din;
`ifdef UART_PARITY_EN
                    tx_par    <= ^din;
`endif
                    tx_cnt    <= '0;
                    txd       <= 1'b0;
                    send_over <= 1'b0;
                    tx_state  <= START;
                end
            end else if (tx_cnt != LAST) begin
                tx_cnt <= tx_cnt + ONE;
            end else begin
                tx_cnt <= '0;
                case (tx_state)
                    START: begin
                        txd      <= tx_shift[0];
                        tx_bit   <= '0;
                        tx_state <= DATA;
                    end
                    DATA: begin
                        if (tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                            txd      <= tx_par;
                            tx_state <= PARITY;
`else
                            txd      <= 1'b1;
                            tx_state <= STOP;
`endif
                        end else begin
                            txd      <= tx_shift[1];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx_bit   <= tx_bit + 3'd1;
                        end
                    end
`ifdef UART_PARITY_EN
                    PARITY: begin
                        txd      <= 1'b1;
                        tx_state <= STOP;
                    end
`endif
                    STOP: begin
                        send_over <= 1'b1;
                        tx_state  <= IDLE;
                    end
                    default: tx_state <= IDLE;
                endcase
            end
        end
    end

    state_t          rx_state;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shift;
    logic            sync1, sync2, sync3;
    logic            rdn_prev;
    logic            rx_par_bad;
`ifndef UART_PARITY_EN
    assign rx_par_bad = 1'b0;
`endif

    always_ff @(posedge clk_sample) begin
        if (rst) begin
            rx_state   <= IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            sync3      <= 1'b1;
            rdn_prev   <= 1'b1;
            dout       <= '0;
            data_ready <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_bad <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            sync1    <= rxd;
            sync2    <= sync1;
            sync3    <= sync2;
            rdn_prev <= rdn;
            // A completing byte assigns data_ready later in this block, so set beats clear.
            if (rdn_prev && !rdn)
                data_ready <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (rx_state)
                IDLE: begin
                    // The detect cycle itself is the first count of the half-bit wait.
                    if (sync3 && !sync2) begin
                        rx_cnt   <= ONE;
                        rx_state <= START;
                    end
                end
                START: begin
                    if (rx_cnt == HALF) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= sync2 ? IDLE : DATA;
                    end else begin
                        rx_cnt <= rx_cnt + ONE;
                    end
                end
                DATA: begin
                    if (rx_cnt == LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {sync2, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                            rx_state <= PARITY;
`else
                            rx_state <= STOP;
`endif
                        end
                    end else begin
                        rx_cnt <= rx_cnt + ONE;
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (rx_cnt == LAST) begin
                        rx_cnt     <= '0;
                        rx_par_bad <= sync2 ^ (^rx_shift);
                        rx_state   <= STOP;
                    end else begin
                        rx_cnt <= rx_cnt + ONE;
                    end
                end
`endif
                STOP: begin
                    if (rx_cnt == LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= IDLE;
`ifdef UART_PARITY_EN
                        parity_err <= rx_par_bad;
`endif
                        if (sync2 && !rx_par_bad) begin
                            dout       <= rx_shift;
                            data_ready <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + ONE;
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transceiver.sv
// tb/tb_uart_transceiver.sv - table-driven and scoreboard bench for uart_transceiver
module tb_uart_transceiver;

    logic       clk_sample = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       wrn;
    logic       txd;
    logic       send_over;
    logic       rxd;
    logic [7:0] dout;
    logic       rdn;
    logic       data_ready;
    logic       rx_drv;
    logic       loopback;
`ifdef UART_PARITY_EN
    logic       parity_err;
`endif

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    always #5 clk_sample = ~clk_sample;

    assign rxd = loopback ? txd : rx_drv;

    uart_transceiver #(.OVERSAMPLE(16)) dut (
        .clk_sample (clk_sample),
        .rst        (rst),
        .din        (din),
        .wrn        (wrn),
        .txd        (txd),
        .send_over  (send_over),
        .rxd        (rxd),
        .dout       (dout),
        .rdn        (rdn),
        .data_ready (data_ready)
`ifdef UART_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    typedef struct packed {
        logic [7:0] data;
        logic       stop_bit;
        logic       do_read;
        logic [7:0] exp_dout;
        logic       exp_ready;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = fr[i];
            repeat (16) @(negedge clk_sample);
        end
        rx_drv = 1'b1;
        repeat (4) @(negedge clk_sample);
    endtask

    task automatic write_byte(input logic [7:0] b);
        wrn = 1'b1;
        @(negedge clk_sample);
        din = b;
        wrn = 1'b0;
        @(negedge clk_sample);
        wrn = 1'b1;
    endtask

    task automatic read_pulse();
        rdn = 1'b0;
        @(negedge clk_sample);
        rdn = 1'b1;
        @(negedge clk_sample);
    endtask

    task automatic wait_signal(input string name, input int which, input int limit);
        int n;
        n = 0;
        while (((which == 0) ? send_over : data_ready) !== 1'b1 && n < limit) begin
            @(negedge clk_sample);
            n++;
        end
        check(name, {31'd0, (which == 0) ? send_over : data_ready}, 32'd1);
    endtask

    // Scoreboard: every newly presented byte must match the oldest expected one.
    initial begin : monitor
        logic       dr_prev;
        logic [7:0] dout_prev;
        logic [7:0] e;
        dr_prev   = 1'b0;
        dout_prev = 8'h00;
        forever begin
            @(negedge clk_sample);
            if (!rst && data_ready === 1'b1 && (!dr_prev || dout !== dout_prev)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {24'd0, dout}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_dout", {24'd0, dout}, {24'd0, e});
                end
            end
            dr_prev   = data_ready;
            dout_prev = dout;
        end
    end

    initial begin
        logic [9:0] fr;
        logic       exp_txd;
        int         n;

        vecs[0] = '{8'h55, 1'b0, 1'b0, 8'h73, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1};
        vecs[2] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1};
        vecs[3] = '{8'hC3, 1'b0, 1'b1, 8'h3C, 1'b0};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
        vecs[5] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1};

        rst = 1'b1; wrn = 1'b1; rdn = 1'b1; din = 8'h00; rx_drv = 1'b1; loopback = 1'b0;
        repeat (3) @(negedge clk_sample);
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_send_over", {31'd0, send_over}, 32'd1);
        check("rst_dout", {24'd0, dout}, 32'd0);
        check("rst_data_ready", {31'd0, data_ready}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk_sample);

        // Transmit 0x4A with a cycle-exact txd/send_over trace and an ignored mid-frame write.
        din = 8'h4A;
        wrn = 1'b0;
        fr = {1'b1, 8'h4A, 1'b0};
        for (int i = 1; i <= 160; i++) begin
            @(negedge clk_sample);
            exp_txd = fr[(i - 1) / 16];
            check("tx_txd", {31'd0, txd}, {31'd0, exp_txd});
            check("tx_busy", {31'd0, send_over}, 32'd0);
            if (i == 50) wrn = 1'b1;
            if (i == 51) wrn = 1'b0;
        end
        @(negedge clk_sample);
        check("tx_done", {31'd0, send_over}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sample);
            check("tx_no_requeue", {30'd0, txd, send_over}, 32'd3);
        end
        wrn = 1'b1;
        check("tx_no_rx", {31'd0, data_ready}, 32'd0);

        // Loopback: latency from txd falling to data_ready rising.
        loopback = 1'b1;
        exp_q.push_back(8'h4A);
        @(negedge clk_sample);
        din = 8'h4A;
        wrn = 1'b0;
        n = 0;
        do begin @(negedge clk_sample); n++; end while (txd !== 1'b0 && n < 4);
        wrn = 1'b1;
        check("lb_txd_fall", {31'd0, txd}, 32'd0);
        n = 0;
        do begin @(negedge clk_sample); n++; end while (data_ready !== 1'b1 && n < 300);
        check("lb_latency", n, 32'd154);
        check("lb_dout_4a", {24'd0, dout}, 32'h4A);
        rdn = 1'b0;
        @(negedge clk_sample);
        check("lb_read_clear", {31'd0, data_ready}, 32'd0);
        wait_signal("lb_tx_idle", 0, 200);
        exp_q.push_back(8'h73);
        write_byte(8'h73);
        wait_signal("lb_ready_73", 1, 300);
        repeat (3) @(negedge clk_sample);
        check("lb_held_rdn_no_clear", {31'd0, data_ready}, 32'd1);
        check("lb_dout_73", {24'd0, dout}, 32'h73);
        rdn = 1'b1;
        @(negedge clk_sample);
        read_pulse();
        check("lb_read_clear2", {31'd0, data_ready}, 32'd0);
        wait_signal("lb_tx_idle2", 0, 200);
        loopback = 1'b0;
        repeat (4) @(negedge clk_sample);

        // Directly driven frames: framing errors, overrun, reads.
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].stop_bit) exp_q.push_back(vecs[v].data);
            send_rx(vecs[v].data, vecs[v].stop_bit);
            if (vecs[v].do_read) read_pulse();
            check($sformatf("vec%0d_dout", v), {24'd0, dout}, {24'd0, vecs[v].exp_dout});
            check($sformatf("vec%0d_ready", v), {31'd0, data_ready}, {31'd0, vecs[v].exp_ready});
        end

        // Short low pulse must be rejected at the start-bit check.
        read_pulse();
        check("glitch_pre_clear", {31'd0, data_ready}, 32'd0);
        rx_drv = 1'b0;
        repeat (4) @(negedge clk_sample);
        rx_drv = 1'b1;
        repeat (200) @(negedge clk_sample);
        check("glitch_ready", {31'd0, data_ready}, 32'd0);
        check("glitch_dout", {24'd0, dout}, 32'hFF);
        exp_q.push_back(8'h96);
        send_rx(8'h96, 1'b1);
        check("post_glitch_dout", {24'd0, dout}, 32'h96);
        check("post_glitch_ready", {31'd0, data_ready}, 32'd1);

        // Read edge lands on the same clock as the stop sample.
        exp_q.push_back(8'h69);
        fork
            send_rx(8'h69, 1'b1);
            begin
                @(posedge clk_sample);
                repeat (152) @(posedge clk_sample);
                @(negedge clk_sample);
                rdn = 1'b0;
                @(negedge clk_sample);
                rdn = 1'b1;
            end
        join
        check("collide_ready", {31'd0, data_ready}, 32'd1);
        check("collide_dout", {24'd0, dout}, 32'h69);

        // Reset in the middle of a loopback frame.
        loopback = 1'b1;
        write_byte(8'hE7);
        repeat (60) @(negedge clk_sample);
        rst = 1'b1;
        repeat (3) @(posedge clk_sample);
        @(negedge clk_sample);
        check("mid_rst_txd", {31'd0, txd}, 32'd1);
        check("mid_rst_send_over", {31'd0, send_over}, 32'd1);
        check("mid_rst_ready", {31'd0, data_ready}, 32'd0);
        check("mid_rst_dout", {24'd0, dout}, 32'd0);
        rst = 1'b0;
        repeat (250) @(negedge clk_sample);
        check("after_rst_ready", {31'd0, data_ready}, 32'd0);
        check("after_rst_txd", {30'd0, txd, send_over}, 32'd3);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
